// File: rtl/dm_ctrl.sv
// Data-memory responder for the pipelined core: byte-lane stores, extended sub-word
// loads, misalignment detection and a post-reset zero-clear of the whole array.
module dm_ctrl #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  dm_type,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        ready,
    output logic        misalign
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]    state_r;
    logic [AW-1:0] clr_idx_r;
    logic [31:0]   mem_array_r [DEPTH_WORDS];

    logic [AW-1:0] word_idx_s;
    logic [1:0]    byte_off_s;
    logic [31:0]   rd_word_s;
    logic [31:0]   ld_data_s;
    logic [31:0]   st_word_s;
    logic          aligned_s;
    logic          accept_s;
    logic          unused_s;

    // Pick the halfword/byte addressed by the offset and extend it per access type.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  typ);
        logic [15:0] h;
        logic [7:0]  b;
        logic [31:0] res;
        h = off[1] ? word[31:16] : word[15:0];
        case (off)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            2'b11:   b = word[31:24];
            default: b = 8'h00;
        endcase
        case (typ)
            3'b001:  res = {{16{h[15]}}, h};
            3'b010:  res = {16'h0000, h};
            3'b011:  res = {{24{b[7]}}, b};
            3'b100:  res = {24'h000000, b};
            default: res = word;
        endcase
        return res;
    endfunction

    // Merge store data into the old word, replacing only the selected byte lanes.
    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] data,
                                                input logic [1:0]  off,
                                                input logic [2:0]  typ);
        logic [3:0]  be;
        logic [31:0] lanes;
        logic [31:0] res;
        case (typ)
            3'b001, 3'b010: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                lanes = {2{data[15:0]}};
            end
            3'b011, 3'b100: begin
                be    = 4'b0001 << off;
                lanes = {4{data[7:0]}};
            end
            default: begin
                be    = 4'b1111;
                lanes = data;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? lanes[8*i +: 8] : old[8*i +: 8];
        end
        return res;
    endfunction

    assign word_idx_s = addr[AW+1:2];
    assign byte_off_s = addr[1:0];
    assign unused_s   = ^addr[31:AW+2];
    assign accept_s   = (mem_r | mem_w) & ready;
    assign rd_word_s  = mem_array_r[word_idx_s];
    assign ld_data_s  = load_extract(rd_word_s, byte_off_s, dm_type);
    assign st_word_s  = store_merge(rd_word_s, wdata, byte_off_s, dm_type);

    // Alignment rule depends on access width; reserved types behave as word.
    always_comb begin
        aligned_s = 1'b0;
        case (dm_type)
            3'b001, 3'b010: aligned_s = ~addr[0];
            3'b011, 3'b100: aligned_s = 1'b1;
            default:        aligned_s = (addr[1:0] == 2'b00);
        endcase
    end

    // Array write port: clear sweep while clearing, aligned stores while running.
    always_ff @(posedge clk) begin
        if (state_r == ST_CLEAR) begin
            mem_array_r[clr_idx_r] <= 32'h0000_0000;
        end else if (accept_s && mem_w && aligned_s) begin
            mem_array_r[word_idx_s] <= st_word_s;
        end
    end

    // Clear FSM and registered load/misalign responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_CLEAR;
            clr_idx_r <= '0;
            ready     <= 1'b0;
            rdata     <= 32'h0000_0000;
            rvalid    <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            rvalid   <= 1'b0;
            misalign <= 1'b0;
            case (state_r)
                ST_CLEAR: begin
                    clr_idx_r <= clr_idx_r + 1'b1;
                    if (clr_idx_r == AW'(DEPTH_WORDS - 1)) begin
                        state_r <= ST_RUN;
                        ready   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (accept_s) begin
                        misalign <= ~aligned_s;
                        if (mem_r) begin
                            rvalid <= 1'b1;
                            rdata  <= aligned_s ? ld_data_s : 32'h0000_0000;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    clr_idx_r <= '0;
                    ready     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dm_ctrl.sv
// Directed bench for dm_ctrl with a 16-word array and hand-computed expectations.
module tb_dm_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r, mem_w;
    logic [31:0] addr, wdata;
    logic [2:0]  dm_type;
    logic [31:0] rdata;
    logic        rvalid, ready, misalign;
    int          n_tests = 0;
    int          n_fail  = 0;

    dm_ctrl #(.DEPTH_WORDS(16)) dut (
        .clk(clk), .rst(rst), .mem_r(mem_r), .mem_w(mem_w), .addr(addr),
        .wdata(wdata), .dm_type(dm_type), .rdata(rdata), .rvalid(rvalid),
        .ready(ready), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_r = 1'b0; mem_w = 1'b0; addr = 32'h0; wdata = 32'h0; dm_type = 3'b000;
    endtask

    task automatic req(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] t);
        mem_r = r; mem_w = w; addr = a; wdata = d; dm_type = t;
        step();
        idle();
    endtask

    task automatic clear_sequence(input string tag);
        mem_r = 1'b1; addr = 32'h0000_0020;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i < 16) check({tag, "_ready_low"}, {31'h0, ready}, 32'h0);
            else        check({tag, "_ready_high"}, {31'h0, ready}, 32'h1);
            check({tag, "_no_rvalid"}, {31'h0, rvalid}, 32'h0);
        end
        idle();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        step(); step();
        check("rst_rdata", rdata, 32'h0);
        check("rst_rvalid", {31'h0, rvalid}, 32'h0);
        check("rst_ready", {31'h0, ready}, 32'h0);
        check("rst_misalign", {31'h0, misalign}, 32'h0);
        rst = 1'b1;
        clear_sequence("clr1");

        req(1'b1, 1'b0, 32'h3C, 32'h0, 3'b000);
        check("ld3c_rdata", rdata, 32'h0);
        check("ld3c_rvalid", {31'h0, rvalid}, 32'h1);
        check("ld3c_mis", {31'h0, misalign}, 32'h0);

        req(1'b0, 1'b1, 32'h08, 32'hDEADBEEF, 3'b000);
        check("st08_rvalid", {31'h0, rvalid}, 32'h0);
        req(1'b1, 1'b0, 32'h08, 32'h0, 3'b000);
        check("ld08_rdata", rdata, 32'hDEADBEEF);
        check("ld08_rvalid", {31'h0, rvalid}, 32'h1);
        step();
        check("ld08_pulse_end", {31'h0, rvalid}, 32'h0);
        check("ld08_hold", rdata, 32'hDEADBEEF);

        req(1'b0, 1'b1, 32'h0D, 32'hFFFFFF80, 3'b011);
        req(1'b1, 1'b0, 32'h0D, 32'h0, 3'b011);
        check("lb_0d", rdata, 32'hFFFFFF80);
        req(1'b1, 1'b0, 32'h0D, 32'h0, 3'b100);
        check("lbu_0d", rdata, 32'h00000080);
        req(1'b0, 1'b1, 32'h0E, 32'hABCD1234, 3'b001);
        req(1'b1, 1'b0, 32'h0C, 32'h0, 3'b000);
        check("lw_0c", rdata, 32'h12348000);
        req(1'b1, 1'b0, 32'h0E, 32'h0, 3'b001);
        check("lh_0e", rdata, 32'h00001234);
        req(1'b1, 1'b0, 32'h0C, 32'h0, 3'b001);
        check("lh_0c", rdata, 32'hFFFF8000);
        req(1'b1, 1'b0, 32'h0C, 32'h0, 3'b010);
        check("lhu_0c", rdata, 32'h00008000);

        req(1'b0, 1'b1, 32'h11, 32'hFFFFFFFF, 3'b000);
        check("sw11_mis", {31'h0, misalign}, 32'h1);
        check("sw11_rvalid", {31'h0, rvalid}, 32'h0);
        step();
        check("sw11_mis_end", {31'h0, misalign}, 32'h0);
        req(1'b1, 1'b0, 32'h08, 32'h0, 3'b000);
        req(1'b1, 1'b0, 32'h10, 32'h0, 3'b000);
        check("lw10_unchanged", rdata, 32'h0);
        check("lw10_mis", {31'h0, misalign}, 32'h0);
        req(1'b1, 1'b0, 32'h08, 32'h0, 3'b000);
        req(1'b1, 1'b0, 32'h13, 32'h0, 3'b001);
        check("lh13_rdata", rdata, 32'h0);
        check("lh13_rvalid", {31'h0, rvalid}, 32'h1);
        check("lh13_mis", {31'h0, misalign}, 32'h1);

        req(1'b0, 1'b1, 32'h04, 32'hAAAAAAAA, 3'b000);
        req(1'b1, 1'b1, 32'h04, 32'h55555555, 3'b000);
        check("rw04_old", rdata, 32'hAAAAAAAA);
        req(1'b1, 1'b0, 32'h04, 32'h0, 3'b000);
        check("rw04_new", rdata, 32'h55555555);
        req(1'b0, 1'b1, 32'h44, 32'h13579BDF, 3'b000);
        req(1'b1, 1'b0, 32'h04, 32'h0, 3'b000);
        check("wrap_44", rdata, 32'h13579BDF);

        req(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 3'b000);
        rst = 1'b0;
        #2;
        check("rst2_ready", {31'h0, ready}, 32'h0);
        check("rst2_rdata", rdata, 32'h0);
        step();
        rst = 1'b1;
        clear_sequence("clr2");
        req(1'b1, 1'b0, 32'h20, 32'h0, 3'b000);
        check("ld20_cleared", rdata, 32'h0);
        check("ld20_rvalid", {31'h0, rvalid}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
